cordic_engine: RTL and testbench
================================

CORDIC_ENGINE -- requirements
Module: cordic_engine

Interface
REQ-001 Parameter WIDTH, default 16, sets the x/y/z datapath width in two's complement.
REQ-002 Parameter STAGES, default 16, sets the iteration and pipeline-register count; legal range 1..WIDTH.
REQ-003 Parameter FRAC, default 14, sets the fraction bits of x, y and z (Q(WIDTH-FRAC).FRAC; z in radians).
REQ-004 The block SHALL use one clock and a synchronous, active-high reset; clk and rst are the ports.
REQ-005 Port clk, input, 1, rising-edge clock.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Port in_valid, input, 1, the input sample is present.
REQ-008 Port in_ready, output, 1, the block accepts the input sample this cycle.
REQ-009 Port mode, input, 1, selects the operating mode: 0 = rotation, 1 = vectoring.
REQ-010 Ports x_in, y_in, z_in, input, WIDTH, signed input operands.
REQ-011 Port out_valid, output, 1, the result is present.
REQ-012 Port out_ready, input, 1, the downstream logic accepts the result.
REQ-013 Ports x_out, y_out, z_out, output, WIDTH, signed results.
REQ-014 Port mode_out, output, 1, the mode that travelled with the result.

Function
REQ-015 Global advance enable: en = !out_valid || out_ready; in_ready SHALL equal en combinationally.
REQ-016 A transfer occurs on a cycle where in_valid && in_ready; in_valid with in_ready=0 SHALL NOT be captured.
REQ-017 When en=1, every stage register (x, y, z, mode, valid) SHALL load from its predecessor; stage 0 loads the input, with valid = in_valid.
REQ-018 When en=0, all stage registers SHALL hold, and outputs SHALL stay stable while out_valid && !out_ready.
REQ-019 Latency is exactly STAGES cycles from the accepted input to out_valid, with no stalls.
REQ-020 Throughput is one sample per cycle; simultaneous accept and consume with a full pipeline SHALL lose and duplicate nothing.
REQ-021 Bubbles (valid=0) SHALL propagate, and they never assert out_valid.
REQ-022 Stage i (0-based) uses shift i and constant a_i = atan(2^-i) in Q.FRAC.
REQ-023 Direction for rotation: d = +1 if z >= 0, else -1.
REQ-024 Direction for vectoring: d = +1 if y < 0, else -1.
REQ-025 Stage update: x' = x - d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*a_i.
REQ-026 Shifts are arithmetic, and all add/sub results wrap modulo 2^WIDTH with no saturation.
REQ-027 Negation SHALL be implemented as a conditional invert plus carry-in (no multiplier).
REQ-028 No gain compensation is applied; x/y outputs carry gain K = 1.6468 (STAGES >= 8), and the caller pre-scales.
REQ-029 Valid operating range: rotation |z_in| <= pi/2; vectoring x_in > 0.
REQ-030 Out-of-range inputs SHALL produce defined, wrapped values without a hang or stall.
REQ-031 Results for identical inputs SHALL be independent of stall pattern and neighbouring samples.

Reset
REQ-032 On rst=1 at a clock edge, all stage valid bits and out_valid SHALL clear to 0.
REQ-033 On reset, x_out/y_out/z_out SHALL clear to 0 and mode_out to 0.
REQ-034 On reset, the data registers of all stages SHALL clear to 0.
REQ-035 Reset mid-operation SHALL discard all in-flight samples; no output appears for them afterwards.
REQ-036 in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-037 Shared package cordic_pkg SHALL hold ATAN_TABLE: 32 entries of 32-bit Q2.30 atan(2^-i) constants.
REQ-038 cordic_pkg SHALL hold a function scaling a table entry to Q.FRAC with round-to-nearest, plus the MODE_ROT/MODE_VEC constants.
REQ-039 Sub-module cordic_iter implements one registered stage, parametrised by WIDTH and SHIFT, with the enable, valid and mode passthrough.
REQ-040 cordic_engine SHALL instantiate STAGES copies of cordic_iter in a generate loop.

Verification (WIDTH=16, FRAC=14, STAGES=16; tolerance +/-4 LSB)
REQ-041 Rotation: x=0x26DD, y=0, z=0x2183 (pi/6) -> x_out~14189, y_out~8192, z_out~0, out_valid on cycle 16.
REQ-042 Vectoring: x=0x2000, y=0x2000 -> x_out~19079, y_out~0, z_out~12868 (pi/4), mode_out=1.
REQ-043 Throughput: 20 back-to-back samples with out_ready=1 -> outputs on 20 consecutive cycles starting at latency 16, in order, each matching the reference model.
REQ-044 Stall: stream with out_ready=0 for 5 cycles mid-run -> in_ready=0 during the stall, outputs held stable, no loss or duplication, and order is preserved.
REQ-045 Reset mid-flight: 8 samples accepted, rst pulsed 1 cycle -> out_valid stays 0 until new inputs arrive; a new sample emerges after 16 cycles.
REQ-046 Mixed modes: alternating mode per sample -> each mode_out and result matches its own mode.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: arctangent table, mode encodings and the
// helper that rescales a table entry to the datapath's fraction width.
package cordic_pkg;

   localparam logic MODE_ROT = 1'b0;
   localparam logic MODE_VEC = 1'b1;

   // atan(2^-i) in Q2.30
   localparam logic [31:0] ATAN_TABLE [32] = '{
      32'h3243F6A8, 32'h1DAC6705, 32'h0FADBAFC, 32'h07F56EA6,
      32'h03FEAB76, 32'h01FFD55B, 32'h00FFFAAA, 32'h007FFF55,
      32'h003FFFEA, 32'h001FFFFD, 32'h000FFFFF, 32'h0007FFFF,
      32'h0003FFFF, 32'h0001FFFF, 32'h0000FFFF, 32'h00007FFF,
      32'h00003FFF, 32'h00001FFF, 32'h00000FFF, 32'h000007FF,
      32'h000003FF, 32'h000001FF, 32'h000000FF, 32'h0000007F,
      32'h0000003F, 32'h0000001F, 32'h0000000F, 32'h00000008,
      32'h00000004, 32'h00000002, 32'h00000001, 32'h00000000
   };

   function automatic logic [31:0] atan_scaled(input int idx, input int frac);
      logic [31:0] e;
      int          sh;
      e  = ATAN_TABLE[idx];
      sh = 30 - frac;
      if (sh <= 0) return e << (-sh);
      return (e + (32'd1 << (sh - 1))) >> sh;
   endfunction

endpackage

// File: rtl/cordic_iter.sv
// One registered CORDIC micro-rotation with fixed shift and angle constant;
// valid and mode travel alongside the data and everything holds when i_en=0.
module cordic_iter
   import cordic_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SHIFT = 0,
   parameter int FRAC  = 14
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic             i_valid,
   input  logic             i_mode,
   input  logic [WIDTH-1:0] i_x,
   input  logic [WIDTH-1:0] i_y,
   input  logic [WIDTH-1:0] i_z,
   output logic             o_valid,
   output logic             o_mode,
   output logic [WIDTH-1:0] o_x,
   output logic [WIDTH-1:0] o_y,
   output logic [WIDTH-1:0] o_z
);

   localparam logic [WIDTH-1:0] ANGLE = WIDTH'(atan_scaled(SHIFT, FRAC));

   logic             w_d_pos;
   logic             w_d_neg;
   logic [WIDTH-1:0] w_xs, w_ys;
   logic [WIDTH-1:0] w_xs_c, w_ys_c, w_a_c;
   logic [WIDTH-1:0] w_x_nxt, w_y_nxt, w_z_nxt;

   logic             r_valid, r_mode;
   logic [WIDTH-1:0] r_x, r_y, r_z;

   assign w_xs    = $signed(i_x) >>> SHIFT;
   assign w_ys    = $signed(i_y) >>> SHIFT;
   assign w_d_pos = (i_mode == MODE_VEC) ? i_y[WIDTH-1] : ~i_z[WIDTH-1];
   assign w_d_neg = ~w_d_pos;

   // d=+1: x-ys, y+xs, z-a. Each subtraction is an invert plus carry-in.
   assign w_ys_c  = w_ys  ^ {WIDTH{w_d_pos}};
   assign w_xs_c  = w_xs  ^ {WIDTH{w_d_neg}};
   assign w_a_c   = ANGLE ^ {WIDTH{w_d_pos}};
   assign w_x_nxt = i_x + w_ys_c + {{(WIDTH-1){1'b0}}, w_d_pos};
   assign w_y_nxt = i_y + w_xs_c + {{(WIDTH-1){1'b0}}, w_d_neg};
   assign w_z_nxt = i_z + w_a_c  + {{(WIDTH-1){1'b0}}, w_d_pos};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_mode  <= 1'b0;
         r_x     <= '0;
         r_y     <= '0;
         r_z     <= '0;
      end else if (i_en) begin
         r_valid <= i_valid;
         r_mode  <= i_mode;
         r_x     <= w_x_nxt;
         r_y     <= w_y_nxt;
         r_z     <= w_z_nxt;
      end
   end

   assign o_valid = r_valid;
   assign o_mode  = r_mode;
   assign o_x     = r_x;
   assign o_y     = r_y;
   assign o_z     = r_z;

endmodule

// File: rtl/cordic_engine.sv
// Pipelined CORDIC (rotation/vectoring), one iteration per stage, with a
// single global advance enable so a stalled output freezes the whole pipe.
module cordic_engine
   import cordic_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 16,
   parameter int FRAC   = 14
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    mode,
   input  logic signed [WIDTH-1:0] x_in,
   input  logic signed [WIDTH-1:0] y_in,
   input  logic signed [WIDTH-1:0] z_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [WIDTH-1:0] x_out,
   output logic signed [WIDTH-1:0] y_out,
   output logic signed [WIDTH-1:0] z_out,
   output logic                    mode_out
);

   logic                          w_en;
   logic [STAGES:0]               w_valid;
   logic [STAGES:0]               w_mode;
   logic [STAGES:0][WIDTH-1:0]    w_x, w_y, w_z;

   assign w_en       = ~out_valid | out_ready;
   assign in_ready   = w_en;

   assign w_valid[0] = in_valid;
   assign w_mode[0]  = mode;
   assign w_x[0]     = x_in;
   assign w_y[0]     = y_in;
   assign w_z[0]     = z_in;

   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      cordic_iter #(
         .WIDTH (WIDTH),
         .SHIFT (g),
         .FRAC  (FRAC)
      ) u_iter (
         .clk     (clk),
         .rst     (rst),
         .i_en    (w_en),
         .i_valid (w_valid[g]),
         .i_mode  (w_mode[g]),
         .i_x     (w_x[g]),
         .i_y     (w_y[g]),
         .i_z     (w_z[g]),
         .o_valid (w_valid[g+1]),
         .o_mode  (w_mode[g+1]),
         .o_x     (w_x[g+1]),
         .o_y     (w_y[g+1]),
         .o_z     (w_z[g+1])
      );
   end

   assign out_valid = w_valid[STAGES];
   assign mode_out  = w_mode[STAGES];
   assign x_out     = w_x[STAGES];
   assign y_out     = w_y[STAGES];
   assign z_out     = w_z[STAGES];

endmodule

// File: tb/tb_cordic_engine.sv
// Scoreboard bench for cordic_engine: the driver queues expected results,
// a negedge monitor pops and compares whenever a result is consumed.
module tb_cordic_engine;

   localparam int W  = 16;
   localparam int ST = 16;
   localparam int FR = 14;
   localparam int ATAN_Q14 [16] = '{12868, 7596, 4014, 2037, 1023, 512, 256, 128,
                                    64, 32, 16, 8, 4, 2, 1, 0};

   logic                clk = 1'b0;
   logic                rst;
   logic                in_valid, in_ready, mode;
   logic signed [W-1:0] x_in, y_in, z_in;
   logic                out_valid, out_ready, mode_out;
   logic signed [W-1:0] x_out, y_out, z_out;

   typedef struct {
      logic signed [15:0] x, y, z;
      logic               m;
      int                 tol;
      int                 due;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   cordic_engine #(.WIDTH(W), .STAGES(ST), .FRAC(FR)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .x_in      (x_in),
      .y_in      (y_in),
      .z_in      (z_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .x_out     (x_out),
      .y_out     (y_out),
      .z_out     (z_out),
      .mode_out  (mode_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input int act, input int exp, input int tol);
      total++;
      if (act - exp > tol || exp - act > tol) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d tol=%0d t=%0t", nm, act, exp, tol, $time);
      end
   endtask

   task automatic fail(input string nm);
      total++;
      bad++;
      $display("FAIL %s t=%0t", nm, $time);
   endtask

   // Independent integer reference of the iteration, wrapping at 16 bits.
   task automatic cordic_model(input logic signed [15:0] xi, yi, zi, input logic m,
                               output logic signed [15:0] xo, yo, zo);
      logic signed [15:0] x, y, z, xs, ys, a;
      logic               dpos;
      x = xi; y = yi; z = zi;
      for (int i = 0; i < 16; i++) begin
         xs   = x >>> i;
         ys   = y >>> i;
         a    = 16'(ATAN_Q14[i]);
         dpos = m ? (y < 0) : (z >= 0);
         if (dpos) begin
            x = x - ys; y = y + xs; z = z - a;
         end else begin
            x = x + ys; y = y - xs; z = z + a;
         end
      end
      xo = x; yo = y; zo = z;
   endtask

   task automatic send(input logic signed [15:0] x, y, z, input logic m,
                       input logic signed [15:0] ex, ey, ez, input int tol, input bit lc);
      exp_t e;
      int   n;
      in_valid = 1'b1; x_in = x; y_in = y; z_in = z; mode = m;
      n = 0;
      @(negedge clk);
      while (!in_ready) begin
         n++;
         if (n > 100) begin
            fail("accept_timeout");
            in_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      e.x = ex; e.y = ey; e.z = ez; e.m = m; e.tol = tol;
      e.due = lc ? cyc + ST : -1;
      sbq.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic msend(input int x, y, z, input logic m, input bit lc);
      logic signed [15:0] ex, ey, ez;
      cordic_model(16'(x), 16'(y), 16'(z), m, ex, ey, ez);
      send(16'(x), 16'(y), 16'(z), m, ex, ey, ez, 0, lc);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      if (sbq.size() != 0) fail("drain_timeout");
      @(posedge clk); #1;
   endtask

   // Monitor: consume results, check stall behaviour and hold stability.
   logic signed [15:0] hx, hy, hz;
   logic               hm;
   bit                 held = 1'b0;
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            held = 1'b0;
         end else begin
            if (held && out_valid) begin
               check("hold_x", x_out, hx, 0);
               check("hold_y", y_out, hy, 0);
               check("hold_z", z_out, hz, 0);
               check("hold_mode", int'(mode_out), int'(hm), 0);
            end
            if (out_valid && !out_ready) begin
               check("stall_in_ready", int'(in_ready), 0, 0);
               hx = x_out; hy = y_out; hz = z_out; hm = mode_out;
               held = 1'b1;
            end else begin
               held = 1'b0;
            end
            if (out_valid && out_ready) begin
               if (sbq.size() == 0) begin
                  fail("unexpected_output");
               end else begin
                  e = sbq.pop_front();
                  check("x_out", x_out, e.x, e.tol);
                  check("y_out", y_out, e.y, e.tol);
                  check("z_out", z_out, e.z, e.tol);
                  check("mode_out", int'(mode_out), int'(e.m), 0);
                  if (e.due >= 0) check("latency", cyc, e.due, 0);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = 1'b0;
      x_in = '0; y_in = '0; z_in = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", int'(out_valid), 0, 0);
      check("rst_x_out", x_out, 0, 0);
      check("rst_mode_out", int'(mode_out), 0, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", int'(in_ready), 1, 0);
      @(posedge clk); #1;

      // Hand-derived vectors
      send(16'sd9949, 16'sd0, 16'sd8579, 1'b0, 16'sd14189, 16'sd8192, 16'sd0, 4, 1'b1);
      drain();
      send(16'sd8192, 16'sd8192, 16'sd0, 1'b1, 16'sd19079, 16'sd0, 16'sd12868, 4, 1'b1);
      drain();
      send(16'sd8192, 16'sd8192, 16'sd0, 1'b1, 16'sd19080, -16'sd1, 16'sd12869, 0, 1'b1);
      drain();

      // Boundary and out-of-range samples (wrapping, no hang)
      msend(9949, 0, 25736, 1'b0, 1'b1);
      msend(9949, 0, -25736, 1'b0, 1'b1);
      msend(32767, 32767, 32767, 1'b0, 1'b1);
      msend(-5000, 3000, 0, 1'b1, 1'b1);
      drain();

      // Back-to-back throughput: consecutive outputs at fixed latency
      for (int k = 0; k < 20; k++)
         msend(6000 + k * 150, k * 100 - 1000, 25000 - k * 2600, 1'b0, 1'b1);
      drain();

      // Alternating modes
      for (int k = 0; k < 10; k++) begin
         if (k % 2 == 0) msend(9949 - k * 300, k * 200, k * 1500 - 7000, 1'b0, 1'b1);
         else            msend(4000 + k * 500, k * 700 - 3000, k * 100, 1'b1, 1'b1);
      end
      drain();

      // Output stall mid-stream
      fork
         begin
            for (int k = 0; k < 24; k++)
               msend(9949, 0, k * 2000 - 23000, k[0], 1'b0);
         end
         begin
            repeat (22) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();

      // Reset while samples are in flight
      for (int k = 0; k < 8; k++)
         msend(9949, 0, k * 1000, 1'b1, 1'b0);
      rst = 1'b1;
      sbq.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", int'(out_valid), 0, 0);
      check("midrst_x_out", x_out, 0, 0);
      check("midrst_y_out", y_out, 0, 0);
      check("midrst_z_out", z_out, 0, 0);
      check("midrst_mode_out", int'(mode_out), 0, 0);
      check("midrst_in_ready", int'(in_ready), 1, 0);
      begin
         int seen;
         seen = 0;
         repeat (25) begin
            @(negedge clk);
            if (out_valid) seen++;
         end
         check("midrst_no_output", seen, 0, 0);
      end
      @(posedge clk); #1;
      msend(9949, 0, 4000, 1'b0, 1'b1);
      drain();

      check("scoreboard_empty", sbq.size(), 0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
